// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state type and default width for the serial adder.
package serial_adder_pkg;
  localparam int DEF_WIDTH = 8;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;
endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// full_adder: 1-bit full adder, the datapath reused every cycle by serial_adder_ctrl.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial A+B+CIN over WIDTH cycles, LSB first, with start/busy/done handshake.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  state_t state, nxt;
  logic [WIDTH-1:0] a_sh, b_sh, r_nx;
  logic [WIDTH-2:0] r_sh;
  logic [CW-1:0] cnt;
  logic carry, fa_sum, fa_carry, last;
  full_adder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .carry(fa_carry)
  );
  // r_sh keeps only the upper WIDTH-1 result bits; the new bit completes the word
  assign r_nx = {fa_sum, r_sh};
  assign last = cnt == CW'(WIDTH - 1);
  assign busy = state == RUN;
  assign done = state == DONE;
  always_comb begin
    nxt = IDLE;
    nxt = (state == IDLE) ? (start ? RUN : IDLE) : (state == RUN) ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      r_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else if (state == IDLE && start) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      r_sh  <= r_nx[WIDTH-1:1];
      carry <= fa_carry;
      cnt   <= last ? cnt : cnt + 1'b1;
      if (last) begin
        sum  <= r_nx;
        cout <= fa_carry;
`ifdef SERIAL_ADDER_OVF_EN
        ovf  <= carry ^ fa_carry;
`endif
      end
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed checks of serial_adder_ctrl at WIDTH=8 plus exhaustive WIDTH=4.
module tb_serial_adder_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic start8 = 1'b0, cin8 = 1'b0, busy8, done8, cout8;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic start4 = 1'b0, cin4 = 1'b0, busy4, done4, cout4;
  logic [3:0] a4 = '0, b4 = '0, sum4;
`ifdef SERIAL_ADDER_OVF_EN
  logic ovf8, ovf4;
`endif
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );
  serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf4)
`endif
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // Issues one addition on dut8, returns result, cycles to done, busy count and done one cycle later
  task automatic do_add(input logic [7:0] a, input logic [7:0] b, input logic c,
                        output logic [7:0] s, output logic co, output int lat,
                        output int busy_n, output logic done_late);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    step();
    start8 = 1'b0;
    lat = 0; busy_n = 0;
    while (!done8 && lat < 30) begin
      if (busy8) busy_n++;
      step();
      lat++;
    end
    s = sum8; co = cout8;
    step();
    done_late = done8;
  endtask
  task automatic test_reset();
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy8); end
    checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done8); end
    checks++; if (sum8 !== 8'h00) begin errors++; $display("FAIL reset_sum got %h want 00", sum8); end
    checks++; if (cout8 !== 1'b0) begin errors++; $display("FAIL reset_cout got %b want 0", cout8); end
    rst = 1'b0;
    step();
  endtask
  task automatic test_zero();
    logic [7:0] s; logic co, dl; int lat, bn;
    do_add(8'h00, 8'h00, 1'b0, s, co, lat, bn, dl);
    checks++; if (lat !== 8) begin errors++; $display("FAIL zero_latency got %0d want 8", lat); end
    checks++; if (bn !== 8) begin errors++; $display("FAIL zero_busy_cycles got %0d want 8", bn); end
    checks++; if ({co, s} !== 9'h000) begin errors++; $display("FAIL zero_result got %h want 000", {co, s}); end
    checks++; if (dl !== 1'b0) begin errors++; $display("FAIL zero_done_width got %b want 0", dl); end
  endtask
  task automatic test_vectors();
    logic [7:0] s; logic co, dl; int lat, bn;
    logic [7:0] va [3] = '{8'hFF, 8'hA5, 8'h3C};
    logic [7:0] vb [3] = '{8'h01, 8'h5A, 8'h0F};
    logic       vc [3] = '{1'b0, 1'b1, 1'b0};
    logic [8:0] ve [3] = '{9'h100, 9'h100, 9'h04B};
    for (int i = 0; i < 3; i++) begin
      do_add(va[i], vb[i], vc[i], s, co, lat, bn, dl);
      checks++; if ({co, s} !== ve[i]) begin errors++; $display("FAIL vec%0d_result got %h want %h", i, {co, s}, ve[i]); end
      checks++; if (lat !== 8 || dl !== 1'b0) begin errors++; $display("FAIL vec%0d_timing got lat=%0d done_late=%b want 8/0", i, lat, dl); end
    end
  endtask
  task automatic test_start_held();
    int n;
    a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; start8 = 1'b1;
    step();
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    n = 0;
    while (!done8 && n < 30) begin step(); n++; end
    checks++; if (n !== 8) begin errors++; $display("FAIL held_latency got %0d want 8", n); end
    checks++; if ({cout8, sum8} !== 9'h033) begin errors++; $display("FAIL held_first_result got %h want 033", {cout8, sum8}); end
    step();
    checks++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin errors++; $display("FAIL held_idle_gap got busy=%b done=%b want 0/0", busy8, done8); end
    step();
    checks++; if (busy8 !== 1'b1) begin errors++; $display("FAIL held_reaccept got busy=%b want 1", busy8); end
    checks++; if (sum8 !== 8'h33) begin errors++; $display("FAIL held_sum_stable got %h want 33", sum8); end
    start8 = 1'b0;
    n = 0;
    while (!done8 && n < 30) begin step(); n++; end
    checks++; if ({cout8, sum8} !== 9'h1FF) begin errors++; $display("FAIL held_second_result got %h want 1ff", {cout8, sum8}); end
    step();
  endtask
  task automatic test_reset_mid();
    logic [7:0] s; logic co, dl; int lat, bn, seen;
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    step();
    start8 = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    #1;
    checks++; if (busy8 !== 1'b0 || sum8 !== 8'h00 || cout8 !== 1'b0)
      begin errors++; $display("FAIL midreset_clear got busy=%b sum=%h cout=%b want 0/00/0", busy8, sum8, cout8); end
    step();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin if (done8) seen++; step(); end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midreset_no_done got %0d pulses want 0", seen); end
    do_add(8'h12, 8'h34, 1'b0, s, co, lat, bn, dl);
    checks++; if ({co, s} !== 9'h046 || lat !== 8) begin errors++; $display("FAIL midreset_recover got %h lat=%0d want 046 lat=8", {co, s}, lat); end
  endtask
  task automatic test_exhaustive4();
    int n; logic [4:0] exp;
    for (int i = 0; i < 512; i++) begin
      a4 = i[3:0]; b4 = i[7:4]; cin4 = i[8]; start4 = 1'b1;
      exp = 5'(i[3:0]) + 5'(i[7:4]) + 5'(i[8]);
      step();
      start4 = 1'b0;
      n = 0;
      while (!done4 && n < 20) begin step(); n++; end
      checks++; if ({cout4, sum4} !== exp || n !== 4) begin errors++; $display("FAIL w4_case%0d got %h lat=%0d want %h lat=4", i, {cout4, sum4}, n, exp); end
      step();
      checks++; if (done4 !== 1'b0) begin errors++; $display("FAIL w4_done_width%0d got %b want 0", i, done4); end
    end
  endtask
`ifdef SERIAL_ADDER_OVF_EN
  task automatic test_ovf();
    logic [7:0] s; logic co, dl; int lat, bn;
    do_add(8'h7F, 8'h01, 1'b0, s, co, lat, bn, dl);
    checks++; if ({ovf8, co, s} !== 10'h280) begin errors++; $display("FAIL ovf_pos got ovf=%b cout=%b sum=%h want 1/0/80", ovf8, co, s); end
    do_add(8'h80, 8'hFF, 1'b0, s, co, lat, bn, dl);
    checks++; if ({ovf8, co, s} !== 10'h37F) begin errors++; $display("FAIL ovf_neg got ovf=%b cout=%b sum=%h want 1/1/7f", ovf8, co, s); end
    do_add(8'h10, 8'h20, 1'b0, s, co, lat, bn, dl);
    checks++; if ({ovf8, co, s} !== 10'h030) begin errors++; $display("FAIL ovf_none got ovf=%b cout=%b sum=%h want 0/0/30", ovf8, co, s); end
  endtask
`endif
  initial begin
    #2;
    test_reset();
    test_zero();
    test_vectors();
    test_start_held();
    test_reset_mid();
    test_exhaustive4();
`ifdef SERIAL_ADDER_OVF_EN
    test_ovf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial adder controller. It computes A + B + CIN for WIDTH-bit operands by reusing one 1-bit full_adder instance for WIDTH cycles, LSB first. The block is the sequencer for the full_adder datapath: it latches operands, shifts bits through the adder, and holds the carry between cycles. It trades latency for area and presents a start/busy/done handshake to its parent.

Parameters:
WIDTH, 8, operand and result width in bits; legal range is 2 to 32.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request a new addition; sampled only in IDLE
a  input  WIDTH  operand A; captured on the accepted start
b  input  WIDTH  operand B; captured on the accepted start
cin  input  1  carry-in; captured on the accepted start
busy  output  1  high while the computation runs (RUN state)
done  output  1  one-cycle pulse when the result is valid
sum  output  WIDTH  result; registered and held until the next result
cout  output  1  carry-out of the MSB; registered and held with sum

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-high on rst.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0. Internal operand shift regs, carry reg and bit counter are also 0.
- FSM states are IDLE, RUN and DONE.
- IDLE: if start=1 at a clk edge:
  - load a_sh<=a, b_sh<=b, carry<=cin, cnt<=0;
  - go to RUN.
  - Otherwise stay in IDLE.
- RUN, on each edge:
  - full_adder inputs: (a_sh[0], b_sh[0], carry);
  - r_sh <= {fa_sum, r_sh[WIDTH-1:1]};
  - carry <= fa_carry;
  - a_sh and b_sh shift right by 1;
  - cnt <= cnt+1.
  - When cnt==WIDTH-1 on that edge: go to DONE, sum<={fa_sum, r_sh[WIDTH-1:1]}, cout<=fa_carry.
- DONE: done=1 for exactly one cycle, then unconditionally return to IDLE.
- busy=1 exactly in RUN, which is WIDTH cycles.
- Latency: start is sampled at edge k; done is high in the cycle after edge k+WIDTH.
- Minimum issue interval is WIDTH+2 cycles.
- start while in RUN or DONE: ignored, with no queuing. Operand changes during RUN have no effect.
- sum and cout change only on the edge that enters DONE, and stay stable otherwise, including through the next RUN.
- Arithmetic: {cout,sum} == a + b + cin, computed modulo 2^(WIDTH+1), zero-extended.
- cnt width is clog2(WIDTH). No wrap-around occurs beyond WIDTH-1.
- rst during RUN: abort immediately, return to the reset values and drop the partial result. No done pulse is produced.
- start asserted in the same cycle rst deasserts: the edge is treated as a normal IDLE sample.

Optional Feature:
Macro SERIAL_ADDER_OVF_EN.
- Defined:
  - add output port ovf (1 bit), giving signed two's-complement overflow;
  - ovf = (carry into the MSB) XOR cout;
  - ovf is captured on the DONE-entry edge together with sum;
  - reset value is 0.
- Undefined: no ovf port and no extra register.

Decomposition:
- Shared package serial_adder_pkg:
  - state enum {IDLE, RUN, DONE}, 2-bit encoding 00/01/10;
  - localparam for the default WIDTH.
- Sub-module: the existing full_adder (ports a, b, cin, sum, carry), instantiated once as the 1-bit datapath. No other sub-modules.

Test Plan:
- WIDTH=8, a=8'h00, b=8'h00, cin=0, start pulse → done exactly 8 cycles after the start edge; sum=8'h00, cout=0; busy high for 8 cycles.
- a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1. Then a=8'hA5, b=8'h5A, cin=1 → sum=8'h00, cout=1.
- Start held high continuously, plus a and b changed during RUN → only the first operands are used; the next accept happens in IDLE after DONE, with a 10-cycle interval.
- Assert rst at the 4th cycle of RUN → busy=0, sum=0, cout=0 immediately; no done pulse. The next start computes correctly.
- WIDTH=4, exhaustive a, b and cin (512 cases) → {cout,sum}==a+b+cin for every case; done is one cycle wide every time.
- With SERIAL_ADDER_OVF_EN, WIDTH=8: 8'h7F+8'h01+0 → ovf=1, sum=8'h80. Then 8'h80+8'hFF+0 → ovf=1, cout=1. Then 8'h10+8'h20 → ovf=0.
